ycbcr_skin_segm: RTL and testbench
==================================

Name: ycbcr_skin_segm

Overview:
Parametrised, pipelined skin-colour segmentation stage for the HDMI video path (hdmi_in → this block → hdmi_out).
- Converts RGB to BT.601 YCbCr and applies Cb/Cr window thresholds.
- Emits one of four selectable video modes with hsync/vsync/de kept aligned to the data.
- Successor to the fixed 8-bit converter-only stage: adds generic width, frame-synchronous threshold/mode update, output modes and optional per-frame skin statistics.

Parameters:
DW, 8, colour component width in bits (8..12)
CNT_W, 22, skin-pixel counter width
CB_MIN_DEF, 77, reset value of the Cb lower bound (8-bit scale)
CB_MAX_DEF, 127, reset value of the Cb upper bound
CR_MIN_DEF, 133, reset value of the Cr lower bound
CR_MAX_DEF, 173, reset value of the Cr upper bound

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active low
ce  in  1  clock enable; 0 freezes the whole pipeline
in_r / in_g / in_b  in  DW each  input RGB
in_hsync / in_vsync / in_de  in  1 each  input timing
cb_min / cb_max / cr_min / cr_max  in  DW each  threshold requests
mode  in  2  output mode request
out_r / out_g / out_b  out  DW each  output video
out_hsync / out_vsync / out_de  out  1 each  aligned timing
skin_count  out  CNT_W  skin pixels in the last complete frame
count_valid  out  1  one-cycle pulse when skin_count updates

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs and pipeline registers are 0. Active thresholds load the *_DEF values shifted left by DW-8. Active mode is 0.
- Latency: fixed 5 enabled cycles from input to output for data and timing alike. Stages:
  - S1: coefficient products.
  - S2: signed sums.
  - S3: offset, arithmetic shift and clamp.
  - S4: threshold compare.
  - S5: output mux.
- When ce=0, every register holds, including the stats counter.
- Conversion uses signed arithmetic of at least DW+10 bits. Let OFS16 = 16<<(DW-8) and OFS128 = 128<<(DW-8).
  - Y = OFS16 + ((66R + 129G + 25B + 128) >>> 8)
  - Cb = OFS128 + ((-38R - 74G + 112B + 128) >>> 8)
  - Cr = OFS128 + ((112R - 94G - 18B + 128) >>> 8)
  - `>>>` is an arithmetic (floor) shift. Each result is clamped to [0, 2^DW-1].
- Skin flag = (cb_min_a ≤ Cb ≤ cb_max_a) AND (cr_min_a ≤ Cr ≤ cr_max_a), with inclusive bounds. If min > max on either channel, the flag is always 0.
- Frame-synchronous update:
  - The block detects an in_vsync rising edge (registered previous value) while ce=1.
  - On that edge, cb_min..cr_max and mode are copied into the active registers.
  - The new values affect pixels entering from the next cycle onward. Requests never change active values mid-frame.
- Modes (active value):
  - 0: out_rgb = {Y, Cb, Cr}.
  - 1: all three channels = all-ones if skin, else 0.
  - 2: delayed RGB if skin, else 0.
  - 3: delayed RGB bypass, skin flag ignored.
- While the delayed de=0, out_r/g/b are forced to 0 in every mode. Timing signals pass through unchanged.

Optional Feature:
SEGM_STATS_EN
- Defined:
  - A counter increments on each enabled cycle where the S5-stage de=1 and skin=1. It saturates at 2^CNT_W-1.
  - On each rising edge of out_vsync, skin_count takes the counter value and count_valid pulses for 1 cycle. In that same cycle the counter clears to 0, or to 1 if a skin pixel coincides.
  - skin_count resets to 0.
- Undefined: skin_count is tied to 0 and count_valid to 0, and no counter logic is present.

Decomposition:
- Package segm_pkg holds:
  - mode encodings MODE_YCBCR = 0, MODE_MASK = 1, MODE_MASKED_RGB = 2, MODE_BYPASS = 3;
  - the nine BT.601 coefficients and rounding constant 128;
  - LATENCY = 5 and CONV_LATENCY = 3.
- Sub-module rgb2ycbcr_p holds stages S1–S3. It is parametrised on DW, takes clk/rst_n/ce, and passes a 3-cycle timing delay line.
- The top-level adds thresholding, the active-register bank, the mux and the stats logic.

Test Plan:
- DW=8, R=G=B=0 with de=1, mode 0 → 5 cycles later out = {16, 128, 128}; R=G=B=255 → {235, 128, 128}.
- DW=8, R=200 G=150 B=120, default thresholds, mode 1 → Y/Cb/Cr = 155/107/152, skin=1, out = {255, 255, 255}; R=G=B=0 → {0, 0, 0}.
- Mode 2 mid-frame request (active mode 0) → output stays in mode 0 until the next in_vsync rise, then pixel (200,150,120) outputs (200,150,120) and black pixels stay black.
- cb_min=130, cb_max=100 latched at vsync → mode 1 output all 0 for any input.
- ce toggled 1/0 alternately over a 10-pixel burst → outputs identical to the ce=1 run, just stretched, with timing still aligned to data.
- SEGM_STATS_EN, 4×4 frame with 6 skin pixels, vsync pulse → count_valid one cycle and skin_count=6. A rst_n low pulse mid-frame → all outputs 0 next cycle and thresholds back to 77/127/133/173.

Source files
------------

// File: rtl/ycbcr_skin_segm_pkg.sv
// rtl/ycbcr_skin_segm_pkg.sv - shared mode encodings, BT.601 coefficients and latencies
package segm_pkg;

  typedef enum logic [1:0] {
    MODE_YCBCR      = 2'd0,
    MODE_MASK       = 2'd1,
    MODE_MASKED_RGB = 2'd2,
    MODE_BYPASS     = 2'd3
  } mode_e;

  localparam int C_Y_R  = 66;
  localparam int C_Y_G  = 129;
  localparam int C_Y_B  = 25;
  localparam int C_CB_R = -38;
  localparam int C_CB_G = -74;
  localparam int C_CB_B = 112;
  localparam int C_CR_R = 112;
  localparam int C_CR_G = -94;
  localparam int C_CR_B = -18;
  localparam int C_RND  = 128;

  localparam int LATENCY      = 5;
  localparam int CONV_LATENCY = 3;

endpackage

// File: rtl/ycbcr_skin_segm_rgb2ycbcr.sv
// rtl/ycbcr_skin_segm_rgb2ycbcr.sv - 3-stage RGB to BT.601 YCbCr converter with timing delay line
module rgb2ycbcr_p
  import segm_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [DW-1:0] i_r,
  input  logic [DW-1:0] i_g,
  input  logic [DW-1:0] i_b,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  output logic [DW-1:0] o_y,
  output logic [DW-1:0] o_cb,
  output logic [DW-1:0] o_cr,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de
);

  localparam int SW = DW + 10;
  typedef logic signed [SW-1:0] sw_t;

  // Coefficient order: {Y, Cb, Cr} rows, each {R, G, B}.
  localparam sw_t K_COEF [9] = '{
    sw_t'(C_Y_R),  sw_t'(C_Y_G),  sw_t'(C_Y_B),
    sw_t'(C_CB_R), sw_t'(C_CB_G), sw_t'(C_CB_B),
    sw_t'(C_CR_R), sw_t'(C_CR_G), sw_t'(C_CR_B)
  };
  localparam sw_t K_RND    = sw_t'(C_RND);
  localparam sw_t K_OFS16  = sw_t'(16 << (DW - 8));
  localparam sw_t K_OFS128 = sw_t'(128 << (DW - 8));
  localparam sw_t K_MAX    = sw_t'((1 << DW) - 1);

  function automatic logic [DW-1:0] clamp(input sw_t v);
    if (v[SW-1])
      return '0;
    else if (v > K_MAX)
      return '1;
    else
      return v[DW-1:0];
  endfunction

  sw_t w_in [3];
  sw_t w_sh [3];
  sw_t r_p  [9];
  sw_t r_s  [3];
  logic [DW-1:0] r_o [3];
  logic [2:0]    r_t [CONV_LATENCY];

  assign w_in[0] = $signed({{(SW-DW){1'b0}}, i_r});
  assign w_in[1] = $signed({{(SW-DW){1'b0}}, i_g});
  assign w_in[2] = $signed({{(SW-DW){1'b0}}, i_b});

  assign w_sh[0] = (r_s[0] >>> 8) + K_OFS16;
  assign w_sh[1] = (r_s[1] >>> 8) + K_OFS128;
  assign w_sh[2] = (r_s[2] >>> 8) + K_OFS128;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_p[i] <= '0;
      for (int c = 0; c < 3; c++) begin
        r_s[c] <= '0;
        r_o[c] <= '0;
      end
      for (int d = 0; d < CONV_LATENCY; d++) r_t[d] <= '0;
    end else if (ce) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < 3; k++) r_p[3*c+k] <= w_in[k] * K_COEF[3*c+k];
        r_s[c] <= r_p[3*c] + r_p[3*c+1] + r_p[3*c+2] + K_RND;
        r_o[c] <= clamp(w_sh[c]);
      end
      r_t[0] <= {i_hsync, i_vsync, i_de};
      for (int d = 1; d < CONV_LATENCY; d++) r_t[d] <= r_t[d-1];
    end
  end

  assign o_y  = r_o[0];
  assign o_cb = r_o[1];
  assign o_cr = r_o[2];
  assign {o_hsync, o_vsync, o_de} = r_t[CONV_LATENCY-1];

endmodule

// File: rtl/ycbcr_skin_segm.sv
// rtl/ycbcr_skin_segm.sv - skin segmentation top: threshold, frame-synced controls, output mux
// Optional per-frame skin pixel statistics enabled by defining SEGM_STATS_EN.
module ycbcr_skin_segm
  import segm_pkg::*;
#(
  parameter int DW         = 8,
  parameter int CNT_W      = 22,
  parameter int CB_MIN_DEF = 77,
  parameter int CB_MAX_DEF = 127,
  parameter int CR_MIN_DEF = 133,
  parameter int CR_MAX_DEF = 173
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_g,
  input  logic [DW-1:0]    in_b,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_de,
  input  logic [DW-1:0]    cb_min,
  input  logic [DW-1:0]    cb_max,
  input  logic [DW-1:0]    cr_min,
  input  logic [DW-1:0]    cr_max,
  input  logic [1:0]       mode,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_g,
  output logic [DW-1:0]    out_b,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_de,
  output logic [CNT_W-1:0] skin_count,
  output logic             count_valid
);

  localparam logic [DW-1:0] K_CB_MIN_RST = DW'(CB_MIN_DEF << (DW - 8));
  localparam logic [DW-1:0] K_CB_MAX_RST = DW'(CB_MAX_DEF << (DW - 8));
  localparam logic [DW-1:0] K_CR_MIN_RST = DW'(CR_MIN_DEF << (DW - 8));
  localparam logic [DW-1:0] K_CR_MAX_RST = DW'(CR_MAX_DEF << (DW - 8));

  logic [DW-1:0]   w_y, w_cb, w_cr;
  logic [2:0]      w_t;
  logic            w_vs_rise;
  logic            w_skin;
  logic [3*DW-1:0] w_mux;

  logic            r_vs_prev;
  logic [3:0]      r_upd;
  logic [DW-1:0]   r_cb_min_p, r_cb_max_p, r_cr_min_p, r_cr_max_p;
  logic [1:0]      r_mode_p;
  logic [DW-1:0]   r_cb_min_a, r_cb_max_a, r_cr_min_a, r_cr_max_a;
  mode_e           r_mode_a;
  logic [3*DW-1:0] r_rgb_d [CONV_LATENCY];
  logic [DW-1:0]   r4_y, r4_cb, r4_cr;
  logic [3*DW-1:0] r4_rgb;
  logic            r4_skin;
  logic [2:0]      r4_t;

  rgb2ycbcr_p #(.DW(DW)) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .i_r     (in_r),
    .i_g     (in_g),
    .i_b     (in_b),
    .i_hsync (in_hsync),
    .i_vsync (in_vsync),
    .i_de    (in_de),
    .o_y     (w_y),
    .o_cb    (w_cb),
    .o_cr    (w_cr),
    .o_hsync (w_t[2]),
    .o_vsync (w_t[1]),
    .o_de    (w_t[0])
  );

  assign w_vs_rise = in_vsync & ~r_vs_prev;

  // Requests are captured at the vsync rise and released into the compare and
  // mux stages only when the first post-rise pixel reaches them, so pixels
  // already in flight finish with the old settings.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_prev  <= 1'b0;
      r_upd      <= '0;
      r_cb_min_p <= K_CB_MIN_RST;
      r_cb_max_p <= K_CB_MAX_RST;
      r_cr_min_p <= K_CR_MIN_RST;
      r_cr_max_p <= K_CR_MAX_RST;
      r_mode_p   <= '0;
      r_cb_min_a <= K_CB_MIN_RST;
      r_cb_max_a <= K_CB_MAX_RST;
      r_cr_min_a <= K_CR_MIN_RST;
      r_cr_max_a <= K_CR_MAX_RST;
      r_mode_a   <= MODE_YCBCR;
    end else if (ce) begin
      r_vs_prev <= in_vsync;
      r_upd     <= {r_upd[2:0], w_vs_rise};
      if (w_vs_rise) begin
        r_cb_min_p <= cb_min;
        r_cb_max_p <= cb_max;
        r_cr_min_p <= cr_min;
        r_cr_max_p <= cr_max;
        r_mode_p   <= mode;
      end
      if (r_upd[2]) begin
        r_cb_min_a <= r_cb_min_p;
        r_cb_max_a <= r_cb_max_p;
        r_cr_min_a <= r_cr_min_p;
        r_cr_max_a <= r_cr_max_p;
      end
      if (r_upd[3]) r_mode_a <= mode_e'(r_mode_p);
    end
  end

  assign w_skin = (w_cb >= r_cb_min_a) && (w_cb <= r_cb_max_a) &&
                  (w_cr >= r_cr_min_a) && (w_cr <= r_cr_max_a);

  always_comb begin
    w_mux = '0;
    case (r_mode_a)
      MODE_YCBCR:      w_mux = {r4_y, r4_cb, r4_cr};
      MODE_MASK:       w_mux = {(3*DW){r4_skin}};
      MODE_MASKED_RGB: w_mux = r4_skin ? r4_rgb : '0;
      MODE_BYPASS:     w_mux = r4_rgb;
    endcase
    if (!r4_t[0]) w_mux = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < CONV_LATENCY; d++) r_rgb_d[d] <= '0;
      r4_y      <= '0;
      r4_cb     <= '0;
      r4_cr     <= '0;
      r4_rgb    <= '0;
      r4_skin   <= 1'b0;
      r4_t      <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
    end else if (ce) begin
      r_rgb_d[0] <= {in_r, in_g, in_b};
      for (int d = 1; d < CONV_LATENCY; d++) r_rgb_d[d] <= r_rgb_d[d-1];
      r4_y    <= w_y;
      r4_cb   <= w_cb;
      r4_cr   <= w_cr;
      r4_rgb  <= r_rgb_d[CONV_LATENCY-1];
      r4_skin <= w_skin;
      r4_t    <= w_t;
      {out_r, out_g, out_b}          <= w_mux;
      {out_hsync, out_vsync, out_de} <= r4_t;
    end
  end

`ifdef SEGM_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovs_prev;
  logic             r5_skin;
  logic             w_ovs_rise;
  logic             w_hit;

  assign w_ovs_rise = out_vsync & ~r_ovs_prev;
  assign w_hit      = out_de & r5_skin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ovs_prev  <= 1'b0;
      r5_skin     <= 1'b0;
      skin_count  <= '0;
      count_valid <= 1'b0;
    end else if (ce) begin
      r5_skin     <= r4_skin;
      r_ovs_prev  <= out_vsync;
      count_valid <= w_ovs_rise;
      if (w_ovs_rise) begin
        skin_count <= r_cnt;
        r_cnt      <= {{(CNT_W-1){1'b0}}, w_hit};
      end else if (w_hit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  assign skin_count  = '0;
  assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ycbcr_skin_segm.sv
// tb/tb_ycbcr_skin_segm.sv - directed self-checking bench for ycbcr_skin_segm (DW=8)
module tb_ycbcr_skin_segm;

  logic        clk = 1'b0;
  logic        rst_n, ce;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_hsync, in_vsync, in_de;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic [1:0]  mode;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_hsync, out_vsync, out_de;
  logic [21:0] skin_count;
  logic        count_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ycbcr_skin_segm dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .mode(mode),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
    .skin_count(skin_count), .count_valid(count_valid)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_r = r; in_g = g; in_b = b; in_de = 1'b1; in_hsync = 1'b1;
  endtask

  task automatic blank();
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; in_de = 1'b0; in_hsync = 1'b0;
  endtask

  task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [1:0] m);
    cb_min = a; cb_max = b; cr_min = c; cr_max = d; mode = m;
  endtask

  task automatic vs_pulse();
    blank();
    in_vsync = 1'b1;
    tick(1);
    in_vsync = 1'b0;
    tick(6);
  endtask

  task automatic run_px(input string tag, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [23:0] exp);
    px(r, g, b);
    tick(1);
    blank();
    tick(4);
    chk(tag, {8'b0, out_r, out_g, out_b}, {8'b0, exp});
    chk({tag, "_tim"}, {29'b0, out_de, out_hsync, out_vsync}, 32'd6);
    tick(1);
    chk({tag, "_end"}, {31'b0, out_de}, 32'd0);
  endtask

  task automatic wait_cv(input string tag);
    int w;
    w = 0;
    while (!count_valid && w < 20) begin
      tick(1);
      w++;
    end
    chk({tag, "_seen"}, {31'b0, count_valid}, 32'd1);
  endtask

  logic [23:0] tin  [4];
  logic [23:0] tout [4];
  logic [25:0] expv;
  logic [15:0] smask;
  int n, e, idx;

  initial begin
    tin  = '{24'h000000, 24'hFFFFFF, 24'hC89678, 24'h0000FF};
    tout = '{24'h108080, 24'hEB8080, 24'h9B6B98, 24'h29F06E};

    ce = 1'b1; rst_n = 1'b0; in_vsync = 1'b0;
    blank();
    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd0);
    tick(2);
    chk("rst_rgb", {8'b0, out_r, out_g, out_b}, 32'd0);
    chk("rst_tim", {29'b0, out_de, out_hsync, out_vsync}, 32'd0);
    chk("rst_stats", {9'b0, count_valid, skin_count}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    px(8'd0, 8'd0, 8'd0);
    tick(1);
    blank();
    tick(3);
    chk("lat_4", {31'b0, out_de}, 32'd0);
    tick(1);
    chk("lat_5_rgb", {8'b0, out_r, out_g, out_b}, 32'h00108080);
    chk("lat_5_tim", {29'b0, out_de, out_hsync, out_vsync}, 32'd6);
    tick(1);

    run_px("y_white", 8'd255, 8'd255, 8'd255, 24'hEB8080);
    run_px("y_skin",  8'd200, 8'd150, 8'd120, 24'h9B6B98);
    run_px("y_blue",  8'd0,   8'd0,   8'd255, 24'h29F06E);

    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd1);
    vs_pulse();
    run_px("m1_skin",  8'd200, 8'd150, 8'd120, 24'hFFFFFF);
    run_px("m1_black", 8'd0,   8'd0,   8'd0,   24'h000000);
    run_px("m1_blue",  8'd0,   8'd0,   8'd255, 24'h000000);

    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd0);
    vs_pulse();
    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd2);
    run_px("mid_req",  8'd200, 8'd150, 8'd120, 24'h9B6B98);
    vs_pulse();
    run_px("m2_skin",  8'd200, 8'd150, 8'd120, 24'hC89678);
    run_px("m2_black", 8'd0,   8'd0,   8'd0,   24'h000000);
    run_px("m2_blue",  8'd0,   8'd0,   8'd255, 24'h000000);

    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd3);
    vs_pulse();
    run_px("m3_blue",  8'd0,   8'd0,   8'd255, 24'h0000FF);

    set_req(8'd107, 8'd107, 8'd152, 8'd152, 2'd1);
    vs_pulse();
    run_px("bound_in", 8'd200, 8'd150, 8'd120, 24'hFFFFFF);
    set_req(8'd108, 8'd127, 8'd133, 8'd173, 2'd1);
    vs_pulse();
    run_px("bound_out", 8'd200, 8'd150, 8'd120, 24'h000000);

    set_req(8'd130, 8'd100, 8'd0, 8'd255, 2'd1);
    vs_pulse();
    run_px("inv_skin",  8'd200, 8'd150, 8'd120, 24'h000000);
    run_px("inv_black", 8'd0,   8'd0,   8'd0,   24'h000000);

    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd0);
    vs_pulse();
    n = 0;
    for (int k = 0; k < 32; k++) begin
      idx = k / 2;
      if (k % 2 == 0) begin
        ce = 1'b1;
        if (idx < 10) begin
          {in_r, in_g, in_b} = tin[idx % 4];
          in_de = 1'b1;
          in_hsync = idx[0];
        end else begin
          blank();
        end
      end else begin
        ce = 1'b0;
        {in_r, in_g, in_b} = 24'($urandom);
        in_de = 1'b1;
        in_hsync = 1'b1;
      end
      tick(1);
      if (k % 2 == 0) n++;
      e = n - 5;
      if (e >= 0 && e < 10) expv = {1'b1, e[0], tout[e % 4]};
      else expv = '0;
      chk("ce_burst", {6'b0, out_de, out_hsync, out_r, out_g, out_b}, {6'b0, expv});
    end
    ce = 1'b1;
    blank();
    tick(6);

`ifdef SEGM_STATS_EN
    set_req(8'd77, 8'd127, 8'd133, 8'd173, 2'd1);
    vs_pulse();
    smask = 16'h8C51;
    for (int p = 0; p < 16; p++) begin
      if (smask[p]) px(8'd200, 8'd150, 8'd120);
      else px(8'd0, 8'd0, 8'd0);
      tick(1);
      if (p % 4 == 3) begin
        blank();
        tick(2);
      end
    end
    blank();
    tick(6);
    chk("cv_idle", {31'b0, count_valid}, 32'd0);
    in_vsync = 1'b1;
    tick(1);
    in_vsync = 1'b0;
    wait_cv("frame6");
    chk("frame6_count", {10'b0, skin_count}, 32'd6);
    tick(1);
    chk("frame6_pulse", {31'b0, count_valid}, 32'd0);
    chk("frame6_hold", {10'b0, skin_count}, 32'd6);
    tick(6);
`else
    smask = 16'h0000;
    chk("nostats", {9'b0, count_valid, skin_count}, {16'b0, smask});
`endif

    set_req(8'd130, 8'd100, 8'd133, 8'd173, 2'd1);
    vs_pulse();
    px(8'd200, 8'd150, 8'd120);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_rgb", {8'b0, out_r, out_g, out_b}, 32'd0);
    chk("mid_rst_tim", {29'b0, out_de, out_hsync, out_vsync}, 32'd0);
    chk("mid_rst_stats", {9'b0, count_valid, skin_count}, 32'd0);
    rst_n = 1'b1;
    blank();
    tick(1);
    run_px("rst_mode0", 8'd200, 8'd150, 8'd120, 24'h9B6B98);
    run_px("rst_black", 8'd0,   8'd0,   8'd0,   24'h108080);

`ifdef SEGM_STATS_EN
    in_vsync = 1'b1;
    tick(1);
    in_vsync = 1'b0;
    wait_cv("rst_thr");
    chk("rst_thr_count", {10'b0, skin_count}, 32'd1);
    tick(6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
